// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared states, widths and digit helpers for the BCD-to-binary converter
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_DIGIT_W = 4;

  // Smallest binary width that can hold 10^digits - 1.
  function automatic int bin_width(input int digits);
    longint p;
    int     w;
    p = 1;
    w = 0;
    for (int i = 0; i < digits; i++) p = p * 10;
    while ((longint'(1) << w) < p) w++;
    return w;
  endfunction

  function automatic logic digit_valid(input logic [3:0] nibble);
    return nibble <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - reverse double-dabble digit correction (subtract 3 from digits >= 8)
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Input is >= 8 whenever the subtract is taken, so no borrow can occur.
  assign dout = (din >= 4'd8) ? din - 4'd3 : din;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - sequential packed-BCD to binary converter, one bit per clock; BCD_TO_BIN_ERRCHK_EN enables invalid-digit detection
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                        busy,
  output logic                        done,
  output logic [BIN_W-1:0]            bin_out,
  output logic                        error
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BCD_W + 1);

  if (BIN_W < bin_width(DIGITS)) begin : g_bin_w_too_small
    $error("bcd_to_bin_seq: BIN_W too small for DIGITS");
  end

  state_t             state, next_state;
  logic [BCD_W-1:0]   bcd_reg, bin_reg;
  logic [BCD_W-1:0]   bcd_sh, bin_sh, bcd_adj;
  logic [CNT_W-1:0]   cnt;
  logic [BIN_W-1:0]   bin_q;
  logic               last;
  logic               bad_in;

  assign {bcd_sh, bin_sh} = {bcd_reg, bin_reg} >> 1;
  assign last = (cnt == CNT_W'(BCD_W - 1));

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (bcd_sh[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

`ifdef BCD_TO_BIN_ERRCHK_EN
  logic err_q;

  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!digit_valid(bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W])) bad_in = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state == IDLE && start) begin
      err_q <= bad_in;
    end
  end

  assign error = err_q;
`else
  assign bad_in = 1'b0;
  assign error  = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = bad_in ? DONE : SHIFT;
      SHIFT:   if (last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
      bin_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bcd_reg <= bcd_in;
            bin_reg <= '0;
            cnt     <= '0;
            if (bad_in) bin_q <= '0;
          end
        end
        SHIFT: begin
          bcd_reg <= bcd_adj;
          bin_reg <= bin_sh;
          cnt     <= cnt + 1'b1;
          // Upper bits of bin_sh are zero for valid BCD, so truncation is exact.
          if (last) bin_q <= bin_sh[BIN_W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign bin_out = bin_q;

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
Sequential packed-BCD to binary converter using the reverse double-dabble algorithm (shift right, then subtract 3 from each digit >= 8).
It is the decode side of the 3-bit ALU's BCD result bus: it turns 8-bit two-digit BCD back into a binary value for downstream arithmetic or a checker.
Start/done handshake; one bit per clock.

Parameters:
DIGITS, 2, number of packed BCD digits on bcd_in.
BIN_W, 7, binary result width; must be >= ceil(log2(10^DIGITS)) (7 for 99).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
start  input  1  request conversion; sampled only in IDLE.
bcd_in  input  4*DIGITS  packed BCD; digit 0 in [3:0]; latched on the accepted start.
busy  output  1  high while the state is not IDLE.
done  output  1  one-cycle pulse when the result or an error is valid.
bin_out  output  BIN_W  converted value; holds until the next completion.
error  output  1  an invalid digit (>9) was seen; valid with done; holds until the next accepted start.

Behaviour:
- Reset (async, immediate): state=IDLE, busy=0, done=0, bin_out=0, error=0, counter=0, shift register=0. Reset mid-conversion aborts the conversion with no done pulse.
- States:
  - IDLE: on start=1 at edge k, latch bcd_in, clear error, cnt=0.
    - Any digit > 9 (check enabled): go to DONE with error=1 and bin_out=0.
    - Otherwise: go to SHIFT.
  - SHIFT: each edge performs one iteration:
    - Shift {bcd_reg, bin_reg} right by 1; the LSB of bcd_reg enters the MSB of bin_reg.
    - Then each 4-bit bcd_reg digit >= 8 gets 3 subtracted.
    - cnt++. On the edge where cnt reaches 4*DIGITS: bin_out = low BIN_W bits of bin_reg, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE on the next edge.
- Latency:
  - Valid input: done is high in the cycle after edge k+4*DIGITS (8 cycles for DIGITS=2).
  - Invalid input: done is high in the cycle after edge k.
- busy=1 from the cycle after the accepted start through the DONE cycle.
- start while busy (SHIFT or DONE) is ignored and not queued. bcd_in changes after the start edge have no effect.
- Back-to-back: start in the first IDLE cycle after DONE is accepted, giving a minimum of 4*DIGITS+2 cycles per conversion.
- Width rules:
  - The internal binary register is 4*DIGITS wide; the upper bits are provably zero for valid input.
  - Digit adjust is a 4-bit subtract with no borrow (input is >= 8).
  - Counter width is clog2(4*DIGITS+1).

Optional Feature:
Macro: BCD_TO_BIN_ERRCHK_EN.
- Defined: invalid-digit detection in IDLE as above; error asserted with done.
- Undefined: no digit check; error is tied to 0; every input is converted through SHIFT. The result for digits > 9 is unspecified and not checked by the bench.

Decomposition:
- Shared package/header bcd_pkg holds:
  - state encodings IDLE=2'd0, SHIFT=2'd1, DONE=2'd2
  - constant BCD_DIGIT_W=4
  - function bin_width(digits) for BIN_W checking
  - function digit_valid(nibble)
- One natural sub-module: bcd_digit_adj. It is combinational: 4-bit in, returns in-3 if in>=8, else in. It is instantiated DIGITS times via generate.

Test Plan:
- bcd_in=8'h99, start one cycle -> busy rises next cycle; after 8 SHIFT edges done=1 for one cycle, bin_out=7'd99, error=0.
- bcd_in=8'h00 then 8'h47 back-to-back (second start in the first IDLE cycle) -> bin_out=0 then 47, two separate done pulses.
- ALU-style stimulus: 8'h12, 8'h35, 8'h02 -> 12, 35, 2 in order; bin_out holds each value until the next done.
- bcd_in=8'h3A with ERRCHK_EN -> done the cycle after the start edge, error=1, bin_out=0; a following start of 8'h21 clears error and gives 21.
- start pulsed at cycles 3 and 6 of a conversion of 8'h58 with bcd_in changed to 8'h11 -> both ignored, single done, bin_out=58.
- reset asserted at SHIFT cycle 4 of 8'h76 -> outputs zero immediately, no done; after release, start 8'h76 -> 76 in 8 cycles.
